// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered loading,
// leading-zero suppression, per-digit blanking and PWM brightness.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 100000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [6:0]              segData,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anSignal,
    output logic                    frame_start
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int OW = CW + BRIGHT_W + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  pending;
    logic [DW-1:0]         sh_digits, act_digits;
    logic [NUM_DIGITS-1:0] sh_dp, act_dp;
    logic [NUM_DIGITS-1:0] sh_blank, act_blank;
    logic                  sh_lz, act_lz;
    logic [BRIGHT_W-1:0]   sh_bright, act_bright;

    logic                  slot_end;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] supp;
    logic                  run;
    logic [3:0]            cur_nib;
    logic                  dark;
    logic [OW-1:0]         on_cycles;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            sh_lz      <= 1'b0;
            sh_bright  <= '1;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_lz     <= 1'b0;
            act_bright <= '1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_lz     <= lz_suppress;
                sh_bright <= brightness;
            end
            // A load on the wrap edge bypasses the shadow stage
            if (load && wrap) begin
                act_digits <= digits_in;
                act_dp     <= dp_in;
                act_blank  <= blank_in;
                act_lz     <= lz_suppress;
                act_bright <= brightness;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (wrap && pending) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_lz     <= sh_lz;
                act_bright <= sh_bright;
                pending    <= 1'b0;
            end
        end
    end

    // Walk from the most significant digit down while everything stays zero
    always_comb begin
        run  = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run     = run & (act_digits[4*i +: 4] == 4'd0) & ~act_dp[i];
            supp[i] = act_lz & run & (i != 0);
        end
    end

    assign cur_nib   = act_digits[{idx, 2'b00} +: 4];
    assign dark      = act_blank[idx] | supp[idx];
    assign on_cycles = ((OW'(act_bright) + 1'b1) * OW'(PRESCALE)) >> BRIGHT_W;
    assign lit       = !dark && (cnt != '0) && (OW'(cnt) <= on_cycles);

    always_comb begin
        an_next = '1;
        if (lit)
            an_next[idx] = 1'b0;
        seg_next = dark ? 7'h7F : decode(cur_nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segData     <= 7'h7F;
            dp_out      <= 1'b1;
            anSignal    <= '1;
            frame_start <= 1'b0;
        end else begin
            segData     <= seg_next;
            dp_out      <= dark | ~act_dp[idx];
            anSignal    <= an_next;
            frame_start <= (idx == '0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-cycle reference model,
// decode vector table and directed multi-cycle sequences.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int B  = 3;
    localparam int FR = N * P;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic [2:0]  brightness;
    logic        load;
    logic [6:0]  segData;
    logic        dp_out;
    logic [3:0]  anSignal;
    logic        frame_start;

    seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BRIGHT_W(B)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress),
        .brightness(brightness), .load(load), .segData(segData),
        .dp_out(dp_out), .anSignal(anSignal), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [2:0]  br;
    } cfg_t;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    localparam cfg_t CFG_RST = '{dig: 16'h0, dp: 4'h0, blank: 4'hF,
                                 lz: 1'b0, br: 3'h7};

    cfg_t sh_m, act_m;
    logic pend_m;
    int   m_t;
    int   n_chk = 0;
    int   n_fail = 0;

    int         f_low[N];
    int         f_lowph[N];
    logic [6:0] f_seg[N];
    logic       f_dp[N];
    int         f_segvar;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // Expected outputs derive from the model state before this edge
    task automatic tick();
        cfg_t       cur;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs, dark, supp, at_wrap;
        int         slot, ph, on;
        cur = '{dig: digits_in, dp: dp_in, blank: blank_in,
                lz: lz_suppress, br: brightness};
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
            m_t = 0; act_m = CFG_RST; sh_m = CFG_RST; pend_m = 1'b0;
        end else begin
            slot = (m_t / P) % N;
            ph   = m_t % P;
            on   = ((int'(act_m.br) + 1) * P) >> B;
            supp = act_m.lz && slot != 0 &&
                   (act_m.dig >> (4 * slot)) == 16'h0 &&
                   (act_m.dp >> slot) == 4'h0;
            dark  = act_m.blank[slot] || supp;
            e_seg = dark ? 7'h7F : seg_of(act_m.dig[4*slot +: 4]);
            e_dp  = dark || !act_m.dp[slot];
            e_an  = (!dark && ph >= 1 && ph <= on) ?
                    ~(4'(1) << slot) : 4'hF;
            e_fs  = (slot == 0) && (ph == 0);
            at_wrap = (m_t % FR) == FR - 1;
            if (load && at_wrap) begin
                act_m = cur; sh_m = cur; pend_m = 1'b0;
            end else if (load) begin
                sh_m = cur; pend_m = 1'b1;
            end else if (at_wrap && pend_m) begin
                act_m = sh_m; pend_m = 1'b0;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        chk("anSignal", 32'(anSignal), 32'(e_an));
        chk("segData", 32'(segData), 32'(e_seg));
        chk("dp_out", 32'(dp_out), 32'(e_dp));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("an_onehot", 32'($countones(~anSignal) <= 1), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz,
                           input logic [2:0] br);
        digits_in = d; dp_in = dp; blank_in = bl;
        lz_suppress = lz; brightness = br; load = 1'b1;
        tick();
        load = 1'b0;
        digits_in = 16'($urandom); dp_in = 4'($urandom);
        blank_in = 4'($urandom); lz_suppress = 1'($urandom);
        brightness = 3'($urandom);
    endtask

    task automatic wait_fs();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FR + 2 && !found; i++) begin
            tick();
            if (frame_start) found = 1'b1;
        end
        if (!found) chk("wait_fs_timeout", 32'd0, 32'd1);
    endtask

    // Observe one full frame starting at the current frame_start sample
    task automatic run_frame();
        for (int d = 0; d < N; d++) begin
            f_low[d] = 0; f_lowph[d] = -1;
        end
        f_segvar = 0;
        for (int t = 0; t < FR; t++) begin
            if (t > 0) tick();
            for (int d = 0; d < N; d++)
                if (!anSignal[d]) begin
                    f_low[d]++;
                    f_lowph[d] = t % P;
                end
            if (t % P == 0) begin
                f_seg[t/P] = segData;
                f_dp[t/P]  = dp_out;
            end else if (segData !== f_seg[t/P]) begin
                f_segvar++;
            end
        end
    endtask

    task automatic chk_lows(input string name, input int l3, input int l2,
                            input int l1, input int l0);
        chk({name, "_d3"}, 32'(f_low[3]), 32'(l3));
        chk({name, "_d2"}, 32'(f_low[2]), 32'(l2));
        chk({name, "_d1"}, 32'(f_low[1]), 32'(l1));
        chk({name, "_d0"}, 32'(f_low[0]), 32'(l0));
    endtask

    initial begin
        vec_t vecs[16];
        int   lit;
        vecs[0]  = '{4'h0, 7'b1000000}; vecs[1]  = '{4'h1, 7'b1111001};
        vecs[2]  = '{4'h2, 7'b0100100}; vecs[3]  = '{4'h3, 7'b0110000};
        vecs[4]  = '{4'h4, 7'b0011001}; vecs[5]  = '{4'h5, 7'b0010010};
        vecs[6]  = '{4'h6, 7'b0000010}; vecs[7]  = '{4'h7, 7'b1111000};
        vecs[8]  = '{4'h8, 7'b0000000}; vecs[9]  = '{4'h9, 7'b0010000};
        vecs[10] = '{4'hA, 7'b0001000}; vecs[11] = '{4'hB, 7'b0000011};
        vecs[12] = '{4'hC, 7'b1000110}; vecs[13] = '{4'hD, 7'b0100001};
        vecs[14] = '{4'hE, 7'b0000110}; vecs[15] = '{4'hF, 7'b0001110};

        reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        blank_in = '0; lz_suppress = 1'b0; brightness = '0;
        m_t = 0; act_m = CFG_RST; sh_m = CFG_RST; pend_m = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_an", 32'(anSignal), 32'hF);
        chk("rst_seg", 32'(segData), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);

        // Dark before any load
        lit = 0;
        for (int i = 0; i < FR + 4; i++) begin
            tick();
            if (anSignal != 4'hF) lit++;
        end
        chk("dark_before_load", 32'(lit), 32'd0);

        do_load(16'h4321, 4'h0, 4'h0, 1'b0, 3'd7);
        wait_fs(); run_frame();
        chk_lows("full", 7, 7, 7, 7);
        chk("full_seg_d0", 32'(f_seg[0]), 32'(7'b1111001));
        chk("full_seg_stable", 32'(f_segvar), 32'd0);
        tick();
        chk("fs_period", 32'(frame_start), 32'd1);

        do_load(16'h4321, 4'h0, 4'h0, 1'b0, 3'd0);
        wait_fs(); run_frame();
        chk_lows("min", 1, 1, 1, 1);
        for (int d = 0; d < N; d++)
            chk("min_phase", 32'(f_lowph[d]), 32'd1);
        chk("min_seg_stable", 32'(f_segvar), 32'd0);

        do_load(16'h0050, 4'h0, 4'h0, 1'b1, 3'd7);
        wait_fs(); run_frame();
        chk_lows("lz50", 0, 0, 7, 7);
        chk("lz50_seg_d1", 32'(f_seg[1]), 32'(7'b0010010));
        chk("lz50_seg_d0", 32'(f_seg[0]), 32'(7'b1000000));
        chk("lz50_seg_d3", 32'(f_seg[3]), 32'h7F);

        do_load(16'h0000, 4'h0, 4'h0, 1'b1, 3'd7);
        wait_fs(); run_frame();
        chk_lows("lz0", 0, 0, 0, 7);
        chk("lz0_seg_d0", 32'(f_seg[0]), 32'(7'b1000000));

        do_load(16'h0005, 4'b0010, 4'h0, 1'b1, 3'd7);
        wait_fs(); run_frame();
        chk_lows("lzdp", 0, 0, 7, 7);
        chk("lzdp_dp_d1", 32'(f_dp[1]), 32'd0);
        chk("lzdp_dp_d0", 32'(f_dp[0]), 32'd1);

        do_load(16'h4321, 4'h0, 4'b0100, 1'b0, 3'd7);
        wait_fs(); run_frame();
        chk_lows("blank", 7, 0, 7, 7);

        for (int v = 0; v < 16; v++) begin
            do_load({4{vecs[v].nib}}, 4'h0, 4'h0, 1'b0, 3'd7);
            wait_fs();
            chk("decode", 32'(segData), 32'(vecs[v].seg));
        end

        // Tear-free: load during the idx=2 slot
        do_load(16'h4321, 4'h0, 4'h0, 1'b0, 3'd7);
        wait_fs();
        for (int k = 0; k < FR && ((m_t % FR) / P) != 2; k++) tick();
        do_load(16'h1111, 4'h0, 4'h0, 1'b0, 3'd7);
        lit = 0;
        for (int k = 0; k < 2 * FR && !frame_start; k++) begin
            tick();
            if (anSignal == 4'b0111) begin
                lit++;
                chk("old_frame_d3", 32'(segData), 32'(7'b0011001));
            end
        end
        chk("old_frame_d3_seen", 32'(lit), 32'd7);
        chk("tear_fs", 32'(frame_start), 32'd1);
        run_frame();
        for (int d = 0; d < N; d++)
            chk("tear_new", 32'(f_seg[d]), 32'(7'b1111001));

        // Load exactly on the wrap edge
        for (int k = 0; k < FR && (m_t % FR) != FR - 1; k++) tick();
        do_load(16'h8888, 4'h0, 4'h0, 1'b0, 3'd7);
        tick();
        chk("wrap_fs", 32'(frame_start), 32'd1);
        chk("wrap_seg", 32'(segData), 32'(7'b0000000));

        // Reset mid-slot with pending shadow data
        for (int k = 0; k < P && (m_t % P) != 4; k++) tick();
        do_load(16'h9999, 4'h0, 4'h0, 1'b0, 3'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_an", 32'(anSignal), 32'hF);
        chk("midrst_seg", 32'(segData), 32'h7F);
        lit = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            if (anSignal != 4'hF) lit++;
        end
        chk("midrst_dark", 32'(lit), 32'd0);

        // Randomized loads and occasional resets against the model
        for (int it = 0; it < 80; it++) begin
            int gap;
            gap = $urandom_range(0, 60);
            for (int g = 0; g < gap; g++) tick();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            do_load(16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00F0),
                    4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom),
                    1'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 2 * FR; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised, time-multiplexed 7-segment scan driver for the board's common-anode display bank. It generalises the fixed 8-digit free-running scanner. Added features:
- configurable digit count and scan rate
- decimal points and per-digit blanking
- leading-zero suppression
- PWM brightness
- tear-free double-buffered loading with a frame marker
It sits between the counter/BCD datapath and the display pins.

Parameters:
NUM_DIGITS, 8, digits scanned; legal 2..16.
PRESCALE, 100000, clk cycles per digit slot; must be >= 2 and >= 2**BRIGHT_W.
BRIGHT_W, 3, brightness control width.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
digits_in  in  4*NUM_DIGITS  hex/BCD nibbles; nibble i = digit i; digit 0 = least significant (rightmost).
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
blank_in  in  NUM_DIGITS  1 = digit fully dark (segments, dp, anode).
lz_suppress  in  1  enable leading-zero suppression.
brightness  in  BRIGHT_W  0 = dimmest, all-ones = full.
load  in  1  one-cycle strobe; samples all inputs above into shadow.
segData  out  7  active-low segments; [0]=a ... [6]=g.
dp_out  out  1  active-low decimal point.
anSignal  out  NUM_DIGITS  active-low anodes; bit i = digit i.
frame_start  out  1  one-cycle pulse at start of each scan frame.

Behaviour:
- Sampling: all input fields are sampled only on load; they are ignored otherwise.
- State:
  - cnt: 0..PRESCALE-1, increments every cycle.
  - idx: 0..NUM_DIGITS-1, increments when cnt == PRESCALE-1.
  - idx wraps NUM_DIGITS-1 -> 0 (the wrap).
- Double buffer:
  - load writes the shadow registers and sets pending.
  - At the wrap edge, if pending is set: active <= shadow and pending is cleared.
  - If load coincides with the wrap edge, the new inputs go straight to active and pending is cleared.
  - Active registers never change mid-frame.
- Decode: hex 0-F, active low. Examples: 0 -> 1000000, 1 -> 1111001, 8 -> 0000000, F -> 0001110.
- Leading-zero suppression (lz_suppress latched):
  - Digit i is suppressed when nibbles i..NUM_DIGITS-1 are all zero and no dp bit is set at positions i..NUM_DIGITS-1.
  - Digit 0 is never suppressed.
  - A suppressed digit behaves as blank.
- Brightness:
  - on_cycles = ((brightness+1)*PRESCALE) >> BRIGHT_W, computed from latched brightness.
  - The anode for idx is asserted when 1 <= cnt <= on_cycles and the digit is not blank or suppressed.
  - cnt == 0 is always a dark dead cycle for anti-ghosting.
  - Full brightness gives PRESCALE-1 on-cycles per slot.
- Latency: all outputs are registered and reflect the (idx, cnt) state of the previous cycle.
  - segData and dp_out carry the decode of the active digit idx for the whole slot.
  - For blank or suppressed digits, segData = 1111111 and dp_out = 1.
- frame_start: high for exactly one cycle, the cycle whose outputs reflect idx=0, cnt=0.
- Reset values:
  - All outputs: anSignal all 1, segData 1111111, dp_out 1, frame_start 0.
  - Internal: cnt=0, idx=0, pending=0, shadow and active digits=0, dp=0, blank all 1, lz=0, brightness all 1.
  - The display stays dark until the first load is transferred.
- Reset mid-operation: everything returns to reset values on the next edge; pending shadow data is discarded.
- Anode exclusivity: at most one anSignal bit is low in any cycle.

Test Plan:
- Scan, full brightness. Setup: NUM_DIGITS=4, PRESCALE=8, BRIGHT_W=3; reset, then load digits=0x4321, blank=0, brightness=7.
  -> After the next frame_start, anSignal steps 1110, 1101, 1011, 0111 with 7 low cycles per 8-cycle slot.
  -> segData reads 1111001 during the digit-0 slot.
  -> frame_start pulses every 32 cycles.
- Minimum brightness. Same setup, brightness=0.
  -> Each anode is low for exactly 1 cycle per slot, at the cycle reflecting cnt=1.
  -> segData is still valid for the whole slot.
- Leading-zero suppression:
  -> digits=0x0050, lz=1: digits 3 and 2 stay dark; digit 1 shows 5, digit 0 shows 0.
  -> digits=0x0000, lz=1: only digit 0 is lit, showing 1000000.
  -> digits=0x0005, lz=1, dp_in=0010: digits 1 and 0 are lit, and dp_out=0 in the digit-1 slot.
- Tear-free load:
  -> load 0x1111 at idx=2, then the old frame finishes unchanged; new data appears starting at the idx=0 slot following frame_start.
  -> load asserted exactly on the wrap edge: the new data is shown in that same frame.
- Blanking and reset:
  -> blank_in=0100: anSignal bit 2 never goes low.
  -> reset asserted mid-slot: the next cycle has anSignal=1111 and segData=1111111; the display stays dark until a new load has been transferred.
